mem_arbiter: RTL and testbench

//  Shares the single external instruction/data memory port between the icache refill engine and the data

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the shared external memory port.
// Icache keeps the port for a whole line refill; data keeps it for one beat.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int I_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ready,
  output logic [XLEN-1:0] i_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata,
  output logic            gnt_i,
  output logic            gnt_d
);

  localparam int CW = (I_BURST > 1) ? $clog2(I_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(I_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  // 1 = icache held the port last, 0 = data did
  logic          last_i_q, last_i_d;

  // Owner, refill beat counter and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_i_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_i_q   <= last_i_d;
    end
  end

  // Arbitration and burst-lock release
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_i_d   = last_i_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || !last_i_q)) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (!i_req || (m_ready && beat_cnt_q == LAST_BEAT)) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          last_i_d   = 1'b1;
        end else if (m_ready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      GNT_D: begin
        if (!d_req || m_ready) begin
          state_d  = IDLE;
          last_i_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port steering: the owner sees the memory, everyone else sees zeros
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = 4'b0000;
    i_ready = 1'b0;
    i_data  = '0;
    d_ready = 1'b0;
    d_rdata = '0;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    unique case (state_q)
      GNT_I: begin
        gnt_i   = 1'b1;
        m_req   = i_req;
        m_addr  = i_addr;
        i_ready = m_ready & i_req;
        i_data  = m_rdata;
      end
      GNT_D: begin
        gnt_d   = 1'b1;
        m_req   = d_req;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
        d_ready = m_ready & d_req;
        d_rdata = m_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed requester traffic against a latency-programmable
// memory model; beats are scored against queued expectations.
module tb_mem_arbiter;
  localparam int XLEN    = 32;
  localparam int I_BURST = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ready;
  logic [XLEN-1:0] i_data;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_wstrb;
  logic            d_ready;
  logic [XLEN-1:0] d_rdata;
  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_ready;
  logic [XLEN-1:0] m_rdata;
  logic            gnt_i;
  logic            gnt_d;

  mem_arbiter #(.XLEN(XLEN), .I_BURST(I_BURST)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .gnt_i(gnt_i), .gnt_d(gnt_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // memory model: ready after lat wait cycles of a held request
  int lat = 0;
  int mcnt = 0;
  assign m_ready = m_req && (mcnt >= lat);
  assign m_rdata = m_req ? mem_fn(m_addr) : 32'h0;
  always @(posedge clk) begin
    if (!m_req || m_ready) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } iexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } dexp_t;

  iexp_t qi[$];
  dexp_t qd[$];
  string gs = "";
  int    last_i_cyc = 0;
  int    last_d_cyc = 0;

  // monitor: score every delivered beat and log grant rises
  initial begin : monitor
    iexp_t ie;
    dexp_t de;
    logic  pgi;
    logic  pgd;
    pgi = 1'b0;
    pgd = 1'b0;
    forever begin
      @(negedge clk);
      if (i_ready) begin
        last_i_cyc = cyc;
        if (qi.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL i_beat_unexpected: got beat at %h expected none", m_addr);
        end else begin
          ie = qi.pop_front();
          chk("i_beat_addr", m_addr, ie.addr);
          chk("i_data", i_data, ie.data);
        end
      end
      if (d_ready) begin
        last_d_cyc = cyc;
        if (qd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d_beat_unexpected: got beat at %h expected none", m_addr);
        end else begin
          de = qd.pop_front();
          chk("d_rdata", d_rdata, de.rdata);
          chk("m_we", {31'd0, m_we}, {31'd0, de.we});
          chk("d_beat_addr", m_addr, de.addr);
          chk("m_wdata", m_wdata, de.wdata);
          chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, de.wstrb});
        end
      end
      if (gnt_d && i_req) chk("i_ready_in_gnt_d", {31'd0, i_ready}, 32'd0);
      if (!gnt_i && !gnt_d)
        chk("idle_m_zero", {m_req, m_we, m_wstrb} | m_addr | m_wdata, 32'd0);
      if (gnt_i && !pgi) gs = {gs, "I"};
      if (gnt_d && !pgd) gs = {gs, "D"};
      pgi = gnt_i;
      pgd = gnt_d;
    end
  end

  task automatic i_burst(input logic [31:0] base);
    int    beats;
    int    guard;
    iexp_t e;
    beats = 0;
    guard = 0;
    for (int k = 0; k < I_BURST; k++) begin
      e.addr = base + 32'(4 * k);
      e.data = mem_fn(e.addr);
      qi.push_back(e);
    end
    i_req  = 1'b1;
    i_addr = base;
    while (beats < I_BURST && guard < 100) begin
      @(negedge clk);
      guard++;
      if (i_ready) begin
        beats++;
        @(posedge clk);
        #1;
        if (beats < I_BURST) i_addr = base + 32'(4 * beats);
      end
    end
    i_req  = 1'b0;
    i_addr = '0;
    if (beats < I_BURST) begin
      checks++;
      failures++;
      $display("FAIL i_burst_timeout: got %0d beats expected %0d", beats, I_BURST);
    end
  endtask

  task automatic d_access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          output int wait_c);
    int    guard;
    int    st;
    logic  done;
    dexp_t e;
    guard  = 0;
    done   = 1'b0;
    wait_c = -1;
    e.we = we; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = mem_fn(a);
    qd.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    st = cyc;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
      if (d_ready) begin
        done   = 1'b1;
        wait_c = cyc - st;
        @(posedge clk);
        #1;
      end
    end
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'b0000;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL d_access_timeout: got no d_ready expected one");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1);
  end

  initial begin : stim
    int w1;
    int w2;
    iexp_t e;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, gnt_i, gnt_d}, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_m", {m_req, m_we, m_wstrb} | m_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: data read, memory ready after 2 wait cycles
    lat = 2;
    fork
      d_access(1'b0, 32'h100, 32'h0, 4'b0000, w1);
      begin
        @(negedge clk);
        chk("t1_bubble_gnt_d", {31'd0, gnt_d}, 32'd0);
        @(negedge clk);
        chk("t1_gnt_d", {31'd0, gnt_d}, 32'd1);
        chk("t1_m_addr", m_addr, 32'h100);
      end
    join
    chk("t1_wait", 32'(w1), 32'd3);
    @(negedge clk);
    chk("t1_back_idle", {30'd0, gnt_i, gnt_d}, 32'd0);
    @(posedge clk);
    #1;

    // 2: lone icache refill
    lat = 0;
    gs  = "";
    i_burst(32'h40);
    @(negedge clk);
    chk("t2_gnt_i_drop", {31'd0, gnt_i}, 32'd0);
    chk_s("t2_grants", gs, "I");
    @(posedge clk);
    #1;

    // 3: simultaneous first requests after reset
    do_reset();
    gs = "";
    fork
      i_burst(32'h80);
      d_access(1'b0, 32'h300, 32'h0, 4'b0000, w1);
    join
    chk_s("t3_grants", gs, "ID");
    chk("t3_gap", 32'(last_d_cyc - last_i_cyc), 32'd2);
    chk("t3_wait", 32'(w1), 32'd6);

    // 4: continuous contention
    gs = "";
    fork
      begin
        i_burst(32'hA0);
        i_burst(32'hC0);
      end
      begin
        d_access(1'b0, 32'h310, 32'h0, 4'b0000, w1);
        d_access(1'b0, 32'h314, 32'h0, 4'b0000, w2);
      end
    join
    chk_s("t4_grants", gs, "IDID");
    chk("t4_wait1", 32'(w1), 32'd6);
    chk("t4_wait2", 32'(w2), 32'd6);

    // 5: data write while icache waits
    gs = "";
    fork
      d_access(1'b1, 32'h200, 32'h1234_5678, 4'b0011, w1);
      begin
        @(posedge clk);
        #1;
        i_burst(32'hE0);
      end
    join
    chk_s("t5_grants", gs, "DI");

    // 6: reset during the second refill beat
    gs = "";
    e.addr = 32'h140;
    e.data = mem_fn(32'h140);
    qi.push_back(e);
    i_req  = 1'b1;
    i_addr = 32'h140;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_beat1", {31'd0, i_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_addr = 32'h144;
    chk("t6_beat2_live", {31'd0, i_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_gnt", {30'd0, gnt_i, gnt_d}, 32'd0);
    chk("t6_rst_ready", {31'd0, i_ready}, 32'd0);
    chk("t6_rst_m", {m_req, m_we, m_wstrb} | m_addr, 32'd0);
    i_req  = 1'b0;
    i_addr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    gs = "";
    i_burst(32'h180);
    chk_s("t6_fresh_burst", gs, "I");

    chk("qi_drained", 32'(qi.size()), 32'd0);
    chk("qd_drained", 32'(qd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
